// File: rtl/ema_pkg.sv
// Shared constants and width helpers for the multi-channel EMA filter.
// Used by ema_datapath (arithmetic widths, rounding) and ema_filter_mc (channel index width).
package ema_pkg;

    // Default coefficient: 0.8125 in Q1.4
    localparam int unsigned COEFF_RESET_DEFAULT = 13;

    // Channel index width, at least one bit
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Difference x - s carries one extra bit so it never wraps
    function automatic int unsigned diff_w(input int unsigned w);
        return w + 1;
    endfunction

    // Full-width product/accumulate width: (w+1) x (f+1) signed, plus headroom for the add
    function automatic int unsigned prod_w(input int unsigned w, input int unsigned f);
        return w + f + 2;
    endfunction

    // Half an LSB of the result, added before the arithmetic shift (round half up)
    function automatic int unsigned round_const(input int unsigned f);
        return (f > 0) ? (32'd1 << (f - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/ema_datapath.sv
// Combinational EMA update: y = sat(s + round((x - s) * b)).
// Ports: x_i sample, s_i channel state, b_i Q1.frac_p coefficient, y_o saturated result.
module ema_datapath
    import ema_pkg::*;
#(
    parameter int unsigned width_p = 24,
    parameter int unsigned frac_p  = 4
) (
    input  logic signed [width_p-1:0] x_i,
    input  logic signed [width_p-1:0] s_i,
    input  logic signed [frac_p:0]    b_i,
    output logic signed [width_p-1:0] y_o
);

    localparam int unsigned DW = diff_w(width_p);
    localparam int unsigned PW = prod_w(width_p, frac_p);

    // Saturation limits expressed at the wide accumulate width
    localparam logic signed [PW-1:0] MAX_V = PW'({1'b0, {(width_p-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

    logic signed [DW-1:0] d;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    logic signed [PW-1:0] sum;

    always_comb begin
        d   = DW'(x_i) - DW'(s_i);
        p   = PW'(d) * PW'(b_i);
        r   = (p + $signed(PW'(round_const(frac_p)))) >>> frac_p;
        sum = PW'(s_i) + r;
        if (sum > MAX_V) begin
            y_o = MAX_V[width_p-1:0];
        end else if (sum < MIN_V) begin
            y_o = MIN_V[width_p-1:0];
        end else begin
            y_o = sum[width_p-1:0];
        end
    end

endmodule

// File: rtl/ema_filter_mc.sv
// Multi-channel exponential moving average filter with a two-stage elastic pipeline.
// Stage A registers the incoming sample/channel; stage B computes y, presents it on
// data_o/chan_o and writes it back as the channel state in the same cycle.
// Ports: clk_i/reset_i (sync, active-high); valid_i/ready_o/data_i/chan_i input beat;
// valid_o/ready_i/data_o/chan_o output beat; cfg_we_i/cfg_clr_i/cfg_chan_i/cfg_coeff_i
// per-channel coefficient write and state clear.
module ema_filter_mc
    import ema_pkg::*;
#(
    parameter int unsigned width_p       = 24,
    parameter int unsigned channels_p    = 4,
    parameter int unsigned frac_p        = 4,
    parameter int          coeff_reset_p = int'(COEFF_RESET_DEFAULT)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [width_p-1:0]                 data_i,
    input  logic [chan_w(channels_p)-1:0]      chan_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [width_p-1:0]                 data_o,
    output logic [chan_w(channels_p)-1:0]      chan_o,
    input  logic                               cfg_we_i,
    input  logic                               cfg_clr_i,
    input  logic [chan_w(channels_p)-1:0]      cfg_chan_i,
    input  logic [frac_p:0]                    cfg_coeff_i
);

    localparam int unsigned CW      = chan_w(channels_p);
    localparam int unsigned BW      = frac_p + 1;
    localparam bit          FULL_CH = (channels_p == (32'd1 << CW));

    logic                      a_valid_q, a_valid_d;
    logic signed [width_p-1:0] a_x_q, a_x_d;
    logic [CW-1:0]             a_c_q, a_c_d;
    logic                      valid_q, valid_d;
    logic signed [width_p-1:0] y_q, y_d;
    logic [CW-1:0]             chan_q, chan_d;
    logic signed [width_p-1:0] s_q [channels_p];
    logic signed [width_p-1:0] s_d [channels_p];
    logic signed [BW-1:0]      b_q [channels_p];
    logic signed [BW-1:0]      b_d [channels_p];

    logic                      a_in_range;
    logic                      cfg_in_range;
    logic                      b_load;
    logic                      accept;
    logic signed [width_p-1:0] s_sel;
    logic signed [BW-1:0]      b_sel;
    logic signed [width_p-1:0] y_calc;

    // Channel indices beyond channels_p only exist when channels_p is not a power of two
    if (FULL_CH) begin : g_full_ch
        assign a_in_range   = 1'b1;
        assign cfg_in_range = 1'b1;
    end else begin : g_part_ch
        assign a_in_range   = (32'(a_c_q) < channels_p);
        assign cfg_in_range = (32'(cfg_chan_i) < channels_p);
    end

    assign b_load  = a_valid_q && (!valid_q || ready_i);
    assign ready_o = !a_valid_q || b_load;
    assign accept  = valid_i && ready_o;

    assign s_sel = a_in_range ? s_q[a_c_q] : '0;
    assign b_sel = a_in_range ? b_q[a_c_q] : '0;

    ema_datapath #(
        .width_p (width_p),
        .frac_p  (frac_p)
    ) u_datapath (
        .x_i (a_x_q),
        .s_i (s_sel),
        .b_i (b_sel),
        .y_o (y_calc)
    );

    // Next-state: pipeline advance, state write-back, then config (clear overrides write-back)
    always_comb begin
        a_valid_d = a_valid_q;
        a_x_d     = a_x_q;
        a_c_d     = a_c_q;
        valid_d   = valid_q;
        y_d       = y_q;
        chan_d    = chan_q;
        s_d       = s_q;
        b_d       = b_q;

        if (b_load) begin
            valid_d = 1'b1;
            y_d     = a_in_range ? y_calc : '0;
            chan_d  = a_c_q;
            if (a_in_range) begin
                s_d[a_c_q] = y_calc;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            a_valid_d = 1'b1;
            a_x_d     = $signed(data_i);
            a_c_d     = chan_i;
        end else if (b_load) begin
            a_valid_d = 1'b0;
        end

        if (cfg_we_i && cfg_in_range) begin
            b_d[cfg_chan_i] = $signed(cfg_coeff_i);
        end
        if (cfg_clr_i && cfg_in_range) begin
            s_d[cfg_chan_i] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_valid_q <= 1'b0;
            a_x_q     <= '0;
            a_c_q     <= '0;
            valid_q   <= 1'b0;
            y_q       <= '0;
            chan_q    <= '0;
            for (int unsigned i = 0; i < channels_p; i++) begin
                s_q[i] <= '0;
                b_q[i] <= BW'(coeff_reset_p);
            end
        end else begin
            a_valid_q <= a_valid_d;
            a_x_q     <= a_x_d;
            a_c_q     <= a_c_d;
            valid_q   <= valid_d;
            y_q       <= y_d;
            chan_q    <= chan_d;
            s_q       <= s_d;
            b_q       <= b_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = y_q;
    assign chan_o  = chan_q;

endmodule

// File: tb/tb_ema_filter_mc.sv
// Directed self-checking bench for ema_filter_mc (width_p=24, channels_p=4, frac_p=4).
module tb_ema_filter_mc;

    localparam int unsigned W   = 24;
    localparam int unsigned CH  = 4;
    localparam int unsigned F   = 4;
    localparam int unsigned CWT = 2;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   data_i;
    logic [CWT-1:0] chan_i;
    logic           valid_o;
    logic           ready_i;
    logic [W-1:0]   data_o;
    logic [CWT-1:0] chan_o;
    logic           cfg_we_i;
    logic           cfg_clr_i;
    logic [CWT-1:0] cfg_chan_i;
    logic [F:0]     cfg_coeff_i;

    int checks = 0;
    int errors = 0;
    int q_data[$];
    int q_chan[$];

    always #5 clk_i = ~clk_i;

    ema_filter_mc #(
        .width_p       (W),
        .channels_p    (CH),
        .frac_p        (F),
        .coeff_reset_p (13)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .chan_i      (chan_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .chan_o      (chan_o),
        .cfg_we_i    (cfg_we_i),
        .cfg_clr_i   (cfg_clr_i),
        .cfg_chan_i  (cfg_chan_i),
        .cfg_coeff_i (cfg_coeff_i)
    );

    // Retired beats, sampled mid-cycle where inputs for the next edge are stable
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && ready_i) begin
            q_data.push_back(int'($signed(data_o)));
            q_chan.push_back(int'(chan_o));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int ch, input int x);
        bit ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        chan_i  = CWT'(ch);
        data_i  = W'(x);
        for (int t = 0; t < 32; t++) begin
            @(negedge clk_i);
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed ready_o low, expected beat ch %0d x %0d accepted", ch, x);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int ch, input int y);
        int t;
        t = 0;
        while (q_data.size() == 0 && t < 32) begin
            tick();
            t++;
        end
        if (q_data.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no output, expected chan %0d y %0d", tag, ch, y);
        end else begin
            check({tag, "_chan"}, q_chan.pop_front(), ch);
            check({tag, "_y"}, q_data.pop_front(), y);
        end
    endtask

    initial begin
        int idx;
        int xs[4];
        int cs[4];
        xs = '{16, 32, 16, 32};
        cs = '{0, 1, 0, 1};

        reset_i     = 1'b1;
        valid_i     = 1'b0;
        data_i      = '0;
        chan_i      = '0;
        ready_i     = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_clr_i   = 1'b0;
        cfg_chan_i  = '0;
        cfg_coeff_i = '0;
        tick();
        tick();
        reset_i = 1'b0;

        check("rst_valid_o", int'(valid_o), 0);
        check("rst_ready_o", int'(ready_o), 1);
        check("rst_data_o", int'(data_o), 0);
        check("rst_chan_o", int'(chan_o), 0);
        tick();
        check("rst_valid_o_after", int'(valid_o), 0);

        // Three back-to-back beats on ch0, each using the state the previous one wrote
        send(0, 16);
        check("lat_not_yet", int'(valid_o), 0);
        send(0, 16);
        check("lat_two_cycles", int'(valid_o), 1);
        send(0, 16);
        expect_out("ch0_b1", 0, 13);
        expect_out("ch0_b2", 0, 15);
        expect_out("ch0_b3", 0, 16);

        // Interleaved channels after clearing ch0
        cfg_clr_i  = 1'b1;
        cfg_chan_i = 2'd0;
        tick();
        cfg_clr_i = 1'b0;
        send(0, 16);
        send(1, 32);
        expect_out("ilv_ch0", 0, 13);
        expect_out("ilv_ch1", 1, 26);

        // Negative coefficient drives positive saturation; small negative input rounds to -1
        cfg_we_i    = 1'b1;
        cfg_chan_i  = 2'd2;
        cfg_coeff_i = 5'h10;
        tick();
        cfg_we_i = 1'b0;
        send(2, -8388608);
        send(3, -1);
        expect_out("sat_pos", 2, 8388607);
        expect_out("neg_one", 3, -1);

        // Backpressure: only two beats fit while downstream stalls
        cfg_clr_i  = 1'b1;
        cfg_chan_i = 2'd0;
        tick();
        cfg_chan_i = 2'd1;
        tick();
        cfg_clr_i = 1'b0;
        ready_i   = 1'b0;
        valid_i   = 1'b1;
        idx       = 0;
        for (int t = 0; t < 6; t++) begin
            if (idx < 4) begin
                chan_i = CWT'(cs[idx]);
                data_i = W'(xs[idx]);
            end
            @(negedge clk_i);
            if (ready_o) idx++;
            tick();
        end
        check("bp_accepted", idx, 2);
        check("bp_ready_o", int'(ready_o), 0);
        check("bp_valid_o", int'(valid_o), 1);
        check("bp_hold_data", int'($signed(data_o)), 13);
        check("bp_hold_chan", int'(chan_o), 0);
        check("bp_no_retire", q_data.size(), 0);
        ready_i = 1'b1;
        for (int t = 0; t < 16 && idx < 4; t++) begin
            chan_i = CWT'(cs[idx]);
            data_i = W'(xs[idx]);
            @(negedge clk_i);
            if (ready_o) idx++;
            tick();
        end
        valid_i = 1'b0;
        check("bp_all_accepted", idx, 4);
        expect_out("bp_r0", 0, 13);
        expect_out("bp_r1", 1, 26);
        expect_out("bp_r2", 0, 15);
        expect_out("bp_r3", 1, 31);

        // Clear coinciding with the ch0 write-back: y still emitted, state ends at zero
        send(0, 16);
        cfg_clr_i  = 1'b1;
        cfg_chan_i = 2'd0;
        tick();
        cfg_clr_i = 1'b0;
        expect_out("clr_hit_y", 0, 16);
        send(0, 16);
        expect_out("clr_after", 0, 13);

        // Coefficient write in the compute cycle: old coefficient used, new one afterwards
        send(3, 15);
        cfg_we_i    = 1'b1;
        cfg_chan_i  = 2'd3;
        cfg_coeff_i = 5'h00;
        tick();
        cfg_we_i = 1'b0;
        expect_out("cfg_old_coeff", 3, 12);
        send(3, 100);
        expect_out("cfg_new_coeff", 3, 12);

        // Reset with both stages full discards the in-flight beats
        ready_i = 1'b0;
        send(0, 16);
        send(1, 32);
        check("full_ready_o", int'(ready_o), 0);
        check("full_valid_o", int'(valid_o), 1);
        reset_i = 1'b1;
        tick();
        check("mid_rst_valid_o", int'(valid_o), 0);
        check("mid_rst_ready_o", int'(ready_o), 1);
        check("mid_rst_data_o", int'(data_o), 0);
        check("mid_rst_chan_o", int'(chan_o), 0);
        reset_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("post_rst_valid_o", int'(valid_o), 0);
        check("post_rst_no_retire", q_data.size(), 0);
        send(2, 16);
        expect_out("post_rst_ch2", 2, 13);
        send(3, 16);
        expect_out("post_rst_ch3", 3, 13);
        send(0, 16);
        expect_out("post_rst_ch0", 0, 13);

        repeat (4) tick();
        check("no_extra_output", q_data.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ema_filter_mc.md
EMA_FILTER_MC -- requirements
Module: ema_filter_mc

Interface
REQ-001 SHALL have parameter width_p, default 24, signed sample width in bits.
REQ-002 SHALL have parameter channels_p, default 4, number of independent filter channels (>=1).
REQ-003 SHALL have parameter frac_p, default 4, coefficient fractional bits; coefficient is signed Q1.frac_p, range [-1, 1-2^-frac_p].
REQ-004 SHALL have parameter coeff_reset_p, default 13 (0.8125 at frac_p=4), coefficient loaded into every channel at reset.
REQ-005 SHALL have ports, one clock domain; reset is synchronous and active-high:
 clk_i  in  1  clock, rising edge
 reset_i  in  1  synchronous active-high reset
 valid_i  in  1  input sample valid
 ready_o  out  1  block can accept input sample
 data_i  in  width_p  signed sample x
 chan_i  in  clog2(channels_p) (min 1)  channel of input sample
 valid_o  out  1  output sample valid
 ready_i  in  1  downstream accepts output
 data_o  out  width_p  signed filtered sample y
 chan_o  out  clog2(channels_p) (min 1)  channel of data_o
 cfg_we_i  in  1  write coefficient cfg_coeff_i to channel cfg_chan_i
 cfg_clr_i  in  1  clear filter state of channel cfg_chan_i to 0
 cfg_chan_i  in  clog2(channels_p) (min 1)  configuration target channel
 cfg_coeff_i  in  frac_p+1  signed coefficient

Function
REQ-006 SHALL keep per-channel state s[c] (width_p signed) and coefficient b[c].
REQ-007 SHALL compute per accepted beat: d = x - s[c] (width_p+1 bits, no wrap); p = d*b[c] (full width); r = (p + 2^(frac_p-1)) >>> frac_p (round half up, arithmetic shift); y = saturate_width_p(s[c] + r).
REQ-008 Saturation SHALL clamp to 2^(width_p-1)-1 and -2^(width_p-1); no wrap-around.
REQ-009 Input handshake: beat accepted when valid_i && ready_o.
REQ-010 Output handshake: beat retired when valid_o && ready_i; data_o/chan_o SHALL hold stable while valid_o && !ready_i.
REQ-011 Two-stage elastic pipeline: stage A registers x, c; stage B computes y from stage A and s[c] on A->B transfer, registers y, c, and writes y into s[c] in the same cycle.
REQ-012 Stage B loads when stage A valid and (!valid_o || ready_i); ready_o = !stageA_valid || stageB_load.
REQ-013 Latency: beat accepted in cycle n SHALL appear on valid_o in cycle n+2 with no backpressure; throughput 1 beat/cycle.
REQ-014 Back-to-back beats on the same channel SHALL each use the state written by the previous beat (no hazard, no stall).
REQ-015 Beats SHALL retire in acceptance order; none lost or duplicated under any ready_i pattern.
REQ-016 cfg_we_i SHALL update b[cfg_chan_i] at the clock edge; a compute in that same cycle on that channel uses the old coefficient.
REQ-017 cfg_clr_i SHALL set s[cfg_chan_i] to 0; when coinciding with a state write to the same channel, clear wins; the computed y is still output.
REQ-018 cfg_we_i and cfg_clr_i SHALL be accepted every cycle, independent of the data handshake.
REQ-019 chan_i/cfg_chan_i >= channels_p: beat/config SHALL be ignored for state and coefficient updates; data beat still passes with y = 0.

Reset
REQ-020 On reset_i: valid_o=0, stage A invalid, ready_o=1 next cycle, all s[c]=0, all b[c]=coeff_reset_p, data_o=0, chan_o=0.
REQ-021 Reset mid-operation SHALL discard all in-flight beats; no valid_o on the cycle after reset deasserts.

Structure
REQ-022 Package ema_pkg SHALL hold the rounding/saturation width helpers and default coefficient constant.
REQ-023 Sub-module ema_datapath SHALL hold the combinational d/p/r/saturate arithmetic; ema_filter_mc holds pipeline, state and config registers.

Verification (frac_p=4, width_p=24)
REQ-024 ch0, b=13, three x=16 beats -> y = 13, 15, 16.
REQ-025 Interleave ch0 x=16, ch1 x=32 -> ch0 y=13, ch1 y=26; chan_o matches.
REQ-026 ch2, b=-16, s=0, x=-8388608 -> y=8388607 (positive saturation); ch3 b=13, x=-1 -> y=-1.
REQ-027 ready_i=0, push 4 beats -> ready_o falls after 2 accepted; release ready_i -> exactly 2 results in order, then remaining 2 accepted.
REQ-028 cfg_clr_i on ch0 coinciding with ch0 state write -> output y, s[0]=0; next x=16 -> y=13.
REQ-029 reset_i asserted with pipeline full -> valid_o=0 next cycle, all states 0, coefficients 13.
